mac_accum: RTL and testbench

MAC_ACCUM -- requirements
Module: mac_accum

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_add4.sv | 54 +++++
 rtl/mac_accum.sv | 153 +++++++++++++++
 tb/tb_mac_accum.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator slice: default widths and the
// job-sequencing FSM state encoding.
package mac_pkg;

    localparam int MAC_DATA_W = 16;
    localparam int MAC_ACC_W  = 24;
    localparam int MAC_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_e;

endpackage

// File: rtl/mac_add4.sv
// Stage 1 of the accumulate pipeline: registered, sign-extended sum of the four
// signed product lanes, carrying the beat's valid and last-of-job flags along.
module mac_add4 import mac_pkg::*; #(
    parameter int DATA_W = MAC_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] lane_0,
    input  logic signed [DATA_W-1:0] lane_1,
    input  logic signed [DATA_W-1:0] lane_2,
    input  logic signed [DATA_W-1:0] lane_3,
    output logic                     out_valid,
    output logic                     out_last,
    output logic signed [DATA_W+1:0] sum4
);

    localparam int SUM_W = DATA_W + 2;

    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;

    // Two guard bits are enough for four lanes; the sum only updates on a real beat.
    always_comb begin
        valid_d = in_valid;
        last_d  = in_valid && in_last;
        sum_d   = sum_q;
        if (in_valid) begin
            sum_d = {{2{lane_0[DATA_W-1]}}, lane_0}
                  + {{2{lane_1[DATA_W-1]}}, lane_1}
                  + {{2{lane_2[DATA_W-1]}}, lane_2}
                  + {{2{lane_3[DATA_W-1]}}, lane_3};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign sum4      = sum_q;

endmodule

// File: rtl/mac_accum.sv
// Multiply-accumulate job engine: accepts acc_len four-lane product beats,
// accumulates them through a two-stage pipeline and presents a saturated result.
module mac_accum import mac_pkg::*; #(
    parameter int DATA_W = MAC_DATA_W,
    parameter int ACC_W  = MAC_ACC_W,
    parameter int LEN_W  = MAC_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LEN_W-1:0]         acc_len,
    input  logic signed [DATA_W-1:0] product_0,
    input  logic signed [DATA_W-1:0] product_1,
    input  logic signed [DATA_W-1:0] product_2,
    input  logic signed [DATA_W-1:0] product_3,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    output logic [DATA_W-1:0]        ofm,
    output logic                     ofm_valid,
    input  logic                     ofm_ready,
    output logic                     sat,
    output logic                     busy
);

    localparam logic signed [ACC_W-1:0] OFM_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OFM_MIN = ~OFM_MAX;
    localparam logic [DATA_W-1:0] OFM_MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] OFM_MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

    mac_state_e state_q, state_d;

    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     acc_last_q, acc_last_d;
    logic [DATA_W-1:0]        ofm_q, ofm_d;
    logic                     sat_q, sat_d;

    logic                     job_start;
    logic                     beat_accept;
    logic                     beat_is_last;
    logic                     s1_valid;
    logic                     s1_last;
    logic signed [DATA_W+1:0] s1_sum;
    logic signed [ACC_W-1:0]  s1_ext;
    logic                     clip_hi;
    logic                     clip_lo;
    logic [DATA_W-1:0]        clip_val;

    assign job_start    = (state_q == IDLE) && start && (acc_len != '0);
    assign beat_accept  = prod_valid && prod_ready;
    assign beat_is_last = (beat_cnt_q + LEN_W'(1)) == len_q;

    mac_add4 #(
        .DATA_W (DATA_W)
    ) u_add4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (beat_accept),
        .in_last   (beat_is_last),
        .lane_0    (product_0),
        .lane_1    (product_1),
        .lane_2    (product_2),
        .lane_3    (product_3),
        .out_valid (s1_valid),
        .out_last  (s1_last),
        .sum4      (s1_sum)
    );

    assign s1_ext   = ACC_W'(s1_sum);
    assign clip_hi  = acc_q > OFM_MAX;
    assign clip_lo  = acc_q < OFM_MIN;
    assign clip_val = clip_hi ? OFM_MAX_D :
                      clip_lo ? OFM_MIN_D : acc_q[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN waits for the last beat to clear stage 2, so the result sees every beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (job_start) state_d = ACC;
            ACC:     if (beat_accept && beat_is_last) state_d = DRAIN;
            DRAIN:   if (acc_last_q) state_d = DONE;
            DONE:    if (ofm_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prod_ready = (state_q == ACC) && (beat_cnt_q < len_q);
        busy       = (state_q != IDLE);
        ofm_valid  = (state_q == DONE);
    end

    always_comb begin
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        acc_d      = acc_q;
        acc_last_d = acc_last_q;
        ofm_d      = ofm_q;
        sat_d      = sat_q;
        if (job_start) begin
            len_d      = acc_len;
            beat_cnt_d = '0;
            acc_d      = '0;
            acc_last_d = 1'b0;
        end
        if (beat_accept) begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
        end
        if (s1_valid) begin
            acc_d = acc_q + s1_ext;
            if (s1_last) begin
                acc_last_d = 1'b1;
            end
        end
        // Result is captured once on entry to DONE and then held for the handshake.
        if ((state_q == DRAIN) && acc_last_q) begin
            ofm_d = clip_val;
            sat_d = clip_hi || clip_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            beat_cnt_q <= '0;
            acc_q      <= '0;
            acc_last_q <= 1'b0;
            ofm_q      <= '0;
            sat_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            acc_q      <= acc_d;
            acc_last_q <= acc_last_d;
            ofm_q      <= ofm_d;
            sat_q      <= sat_d;
        end
    end

    assign ofm = ofm_q;
    assign sat = sat_q;

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: job-level reference model checked every cycle, directed
// jobs with literal results, then randomized traffic.
module tb_mac_accum;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         acc_len = '0;
    logic signed [15:0] product_0 = '0;
    logic signed [15:0] product_1 = '0;
    logic signed [15:0] product_2 = '0;
    logic signed [15:0] product_3 = '0;
    logic               prod_valid = 1'b0;
    logic               prod_ready;
    logic [15:0]        ofm;
    logic               ofm_valid;
    logic               ofm_ready = 1'b0;
    logic               sat;
    logic               busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accepts = 0;

    always #5 clk = ~clk;

    mac_accum #(
        .DATA_W (16),
        .ACC_W  (24),
        .LEN_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .acc_len    (acc_len),
        .product_0  (product_0),
        .product_1  (product_1),
        .product_2  (product_2),
        .product_3  (product_3),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .ofm        (ofm),
        .ofm_valid  (ofm_valid),
        .ofm_ready  (ofm_ready),
        .sat        (sat),
        .busy       (busy)
    );

    task automatic checkOutput(string name, longint actual, longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Job model: phase 0 idle, 1 taking beats, 2 result in flight, 3 result offered.
    int          m_phase = 0;
    int          m_len = 0;
    int          m_taken = 0;
    int          m_cd = 0;
    longint      m_sum = 0;
    logic [15:0] m_ofm = '0;
    logic        m_sat = 1'b0;

    function automatic longint lane_sum();
        return longint'(product_0) + longint'(product_1) + longint'(product_2) + longint'(product_3);
    endfunction

    function automatic logic [16:0] clip_model(longint s);
        logic [23:0] t;
        longint      w;
        t = s[23:0];
        w = $signed(t);
        if (w > 32767) return {1'b1, 16'h7FFF};
        if (w < -32768) return {1'b1, 16'h8000};
        return {1'b0, w[15:0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_taken <= 0;
            m_sum   <= 0;
            m_cd    <= 0;
        end else begin
            case (m_phase)
                0: if (start && acc_len != 0) begin
                    m_len   <= acc_len;
                    m_taken <= 0;
                    m_sum   <= 0;
                    m_phase <= 1;
                end
                1: if (prod_valid && m_taken < m_len) begin
                    m_sum   <= m_sum + lane_sum();
                    m_taken <= m_taken + 1;
                    if (m_taken + 1 == m_len) begin
                        m_phase <= 2;
                        m_cd    <= 2;
                        {m_sat, m_ofm} <= clip_model(m_sum + lane_sum());
                    end
                end
                2: begin
                    if (m_cd == 1) m_phase <= 3;
                    m_cd <= m_cd - 1;
                end
                default: if (ofm_ready) m_phase <= 0;
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("prod_ready", longint'(prod_ready), longint'(m_phase == 1 && m_taken < m_len));
            checkOutput("busy", longint'(busy), longint'(m_phase != 0));
            checkOutput("ofm_valid", longint'(ofm_valid), longint'(m_phase == 3));
            if (m_phase == 3) begin
                checkOutput("ofm", longint'(ofm), longint'(m_ofm));
                checkOutput("sat", longint'(sat), longint'(m_sat));
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (prod_valid && prod_ready) accepts++;
    end

    task automatic applyStimulus(logic pv, logic signed [15:0] a, logic signed [15:0] b,
                                 logic signed [15:0] c, logic signed [15:0] d);
        prod_valid = pv;
        product_0  = a;
        product_1  = b;
        product_2  = c;
        product_3  = d;
    endtask

    task automatic pulse_start(int len);
        @(negedge clk);
        start   = 1'b1;
        acc_len = 8'(len);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_beat(logic signed [15:0] a, logic signed [15:0] b,
                             logic signed [15:0] c, logic signed [15:0] d, output int t_acc);
        int guard = 0;
        @(negedge clk);
        applyStimulus(1'b1, a, b, c, d);
        while (!prod_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) checkOutput("beat_timeout", 0, 1);
        t_acc = cyc;
    endtask

    task automatic send_gap();
        @(negedge clk);
        applyStimulus(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic wait_result(output int t_seen);
        int guard = 0;
        t_seen = -1;
        while (guard < 400) begin
            @(negedge clk);
            if (ofm_valid) begin
                t_seen = cyc;
                break;
            end
            guard++;
        end
        if (t_seen < 0) checkOutput("result_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t, t_last, t_seen, a0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_prod_ready", longint'(prod_ready), 0);
        checkOutput("rst_ofm", longint'(ofm), 0);
        checkOutput("rst_ofm_valid", longint'(ofm_valid), 0);
        checkOutput("rst_sat", longint'(sat), 0);
        checkOutput("rst_busy", longint'(busy), 0);
        #3 rst_n = 1'b1;
        ofm_ready = 1'b1;

        // Basic job with latency check
        pulse_start(3);
        send_beat(1, 2, 3, 4, t);
        send_beat(5, 6, 7, 8, t);
        send_beat(-1, -1, -1, -1, t_last);
        wait_result(t_seen);
        checkOutput("j1_ofm", longint'(ofm), 32);
        checkOutput("j1_sat", longint'(sat), 0);
        checkOutput("j1_latency", longint'(t_seen - t_last), 3);
        checkOutput("j1_model", longint'(m_ofm), 32);
        @(negedge clk) applyStimulus(1'b0, 0, 0, 0, 0);

        // Positive and negative saturation
        pulse_start(2);
        send_beat(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, t);
        send_beat(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, t);
        wait_result(t_seen);
        checkOutput("j2_ofm", longint'(ofm), 32'h7FFF);
        checkOutput("j2_sat", longint'(sat), 1);
        @(negedge clk) applyStimulus(1'b0, 0, 0, 0, 0);
        pulse_start(2);
        send_beat(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, t);
        send_beat(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, t);
        wait_result(t_seen);
        checkOutput("j3_ofm", longint'(ofm), 32'h8000);
        checkOutput("j3_sat", longint'(sat), 1);
        checkOutput("j3_model", longint'(m_ofm), 32'h8000);
        @(negedge clk) applyStimulus(1'b0, 0, 0, 0, 0);

        // Gapped beats and a stalled result
        ofm_ready = 1'b0;
        pulse_start(4);
        send_beat(1, 2, 3, 4, t);
        send_gap();
        send_beat(10, 20, 30, 40, t);
        send_gap();
        send_beat(-5, 0, 0, 0, t);
        send_gap();
        send_beat(100, -50, 7, 3, t);
        @(negedge clk) applyStimulus(1'b0, 0, 0, 0, 0);
        wait_result(t_seen);
        for (int i = 0; i < 5; i++) begin
            checkOutput("j4_ofm_hold", longint'(ofm), 165);
            checkOutput("j4_valid_hold", longint'(ofm_valid), 1);
            checkOutput("j4_ready_low", longint'(prod_ready), 0);
            @(negedge clk);
        end
        ofm_ready = 1'b1;
        @(negedge clk);
        checkOutput("j4_idle_busy", longint'(busy), 0);
        checkOutput("j4_idle_valid", longint'(ofm_valid), 0);

        // Zero-length start ignored; start during ACC ignored
        pulse_start(0);
        checkOutput("j5_len0_busy", longint'(busy), 0);
        a0 = accepts;
        pulse_start(2);
        send_beat(2, 2, 2, 2, t);
        @(negedge clk);
        applyStimulus(1'b0, 0, 0, 0, 0);
        start   = 1'b1;
        acc_len = 8'd5;
        @(negedge clk) start = 1'b0;
        send_beat(3, 3, 3, 3, t);
        wait_result(t_seen);
        checkOutput("j5_ofm", longint'(ofm), 20);
        checkOutput("j5_beats", longint'(accepts - a0), 2);
        @(negedge clk) applyStimulus(1'b0, 0, 0, 0, 0);

        // Reset mid-job, then a job started on the first edge after release
        pulse_start(5);
        send_beat(1, 1, 1, 1, t);
        send_beat(1, 1, 1, 1, t);
        @(negedge clk) applyStimulus(1'b0, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_prod_ready", longint'(prod_ready), 0);
        checkOutput("mid_rst_ofm", longint'(ofm), 0);
        checkOutput("mid_rst_ofm_valid", longint'(ofm_valid), 0);
        checkOutput("mid_rst_sat", longint'(sat), 0);
        checkOutput("mid_rst_busy", longint'(busy), 0);
        repeat (2) @(negedge clk);
        #3;
        rst_n   = 1'b1;
        start   = 1'b1;
        acc_len = 8'd1;
        @(negedge clk) start = 1'b0;
        checkOutput("post_rst_busy", longint'(busy), 1);
        send_beat(1, 1, 1, 1, t);
        wait_result(t_seen);
        checkOutput("j6_ofm", longint'(ofm), 4);
        @(negedge clk) applyStimulus(1'b0, 0, 0, 0, 0);

        // Maximum length job
        a0 = accepts;
        pulse_start(255);
        @(negedge clk) applyStimulus(1'b1, 1, 0, 0, 0);
        wait_result(t_seen);
        checkOutput("j7_ofm", longint'(ofm), 255);
        checkOutput("j7_sat", longint'(sat), 0);
        checkOutput("j7_beats", longint'(accepts - a0), 255);
        @(negedge clk) applyStimulus(1'b0, 0, 0, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start   = ($urandom % 6) == 0;
            acc_len = 8'($urandom % 7);
            applyStimulus(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
                          16'($urandom), 16'($urandom));
            ofm_ready = ($urandom % 3) != 0;
        end
        @(negedge clk);
        start     = 1'b0;
        ofm_ready = 1'b1;
        prod_valid = 1'b1;
        repeat (60) @(negedge clk);
        prod_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("final_idle", longint'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
